// File: rtl/mem_line_master_if.sv
// Bundle of the command, response and line-memory buses of mem_line_master.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on commands; responses and memory data are unthrottled.
//
// Modports:
//   master : the mem_line_master view (drives cmd_ready, rsp_*, req/we/addr/wdata/wstrb)
//   slave  : the environment view (cache controller + line memory)
interface mem_line_master_if #(
    parameter int MAX_BEATS = 4,
    parameter int LEN_W     = $clog2(MAX_BEATS)
);
    // command from the cache controller
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [127:0]     cmd_wdata;
    logic [15:0]      cmd_wstrb;
    // per-beat response
    logic             rsp_valid;
    logic [127:0]     rsp_rdata;
    logic             rsp_last;
    logic             rsp_err;
    // line memory port
    logic             req;
    logic             we;
    logic [31:0]      addr;
    logic [127:0]     wdata;
    logic [15:0]      wstrb;
    logic             gnt;
    logic             rvalid;
    logic [127:0]     rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_wdata, cmd_wstrb,
        input  gnt, rvalid, rdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_last, rsp_err,
        output req, we, addr, wdata, wstrb
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_wdata, cmd_wstrb,
        output gnt, rvalid, rdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_last, rsp_err,
        input  req, we, addr, wdata, wstrb
    );
endinterface

// File: rtl/mem_line_master.sv
// Initiator for the 128-bit line memory: single-line writes and 1..MAX_BEATS-line read bursts.
// Latency: write 4 cycles cmd-to-cmd, read 3 cycles per beat; responses registered (1 cycle after gnt/rvalid).
// Backpressure: cmd_ready only in IDLE; responses cannot be stalled; gnt/rvalid waits bounded by TIMEOUT_CYC.
//
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous reset, active-high (aborts any transaction without a response)
//   bus    : mem_line_master_if.master (command, response and memory buses)
module mem_line_master #(
    parameter int MAX_BEATS   = 4,
    parameter int LEN_W       = $clog2(MAX_BEATS),
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_line_master_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // counter only has to reach TIMEOUT_CYC-1; the timeout fires instead of the next increment
    localparam int TCNT_W = $clog2(TIMEOUT_CYC);

    logic [1:0]        r_state;
    logic              r_we;
    logic [27:0]       r_line;      // current line index, wraps at 28 bits
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic [127:0]      r_wdata;
    logic [15:0]       r_wstrb;
    logic [TCNT_W-1:0] r_tcnt;      // cycles spent in current REQ/RDATA visit
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic              r_rsp_err;
    logic [127:0]      r_rsp_rdata;

    logic w_gnt_q;
    logic w_timeout;
    logic w_last_beat;
    logic w_unused;

    // Grant is registered by the memory, so a gnt seen in the first REQ cycle
    // belongs to the previous request and must not complete this one.
    assign w_gnt_q     = bus.gnt && (r_tcnt != '0);
    assign w_timeout   = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
    assign w_last_beat = (r_beat == r_len);
    assign w_unused    = &{1'b0, bus.cmd_addr[3:0]};

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_line      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_tcnt      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // responses are single-cycle pulses with zero data unless a beat completes
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    if (bus.cmd_valid) begin
                        r_we    <= bus.cmd_we;
                        r_line  <= bus.cmd_addr[31:4];
                        r_len   <= bus.cmd_len;
                        r_wdata <= bus.cmd_wdata;
                        r_wstrb <= bus.cmd_wstrb;
                        r_beat  <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_gnt_q) begin
                        r_tcnt <= '0;
                        if (r_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_last  <= 1'b1;
                            r_state     <= S_GAP;
                        end else begin
                            r_state <= S_RDATA;
                        end
                    end else if (w_timeout) begin
                        r_tcnt      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_RDATA: begin
                    if (bus.rvalid) begin
                        r_tcnt      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= bus.rdata;
                        r_rsp_last  <= w_last_beat;
                        if (w_last_beat) begin
                            // RDATA already kept req low for a cycle, no GAP needed
                            r_state <= S_IDLE;
                        end else begin
                            r_beat  <= r_beat + LEN_W'(1);
                            r_line  <= r_line + 28'd1;
                            r_state <= S_REQ;
                        end
                    end else if (w_timeout) begin
                        r_tcnt      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_GAP: begin
                    // one req-low cycle so the memory's stale grant drains
                    r_tcnt  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_tcnt  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE) && !rst_ni;
    assign bus.req       = (r_state == S_REQ);
    assign bus.we        = r_we;
    assign bus.addr      = {r_line, 4'b0000};
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wstrb;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: line memory responder, per-cycle timeline model, directed commands.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_line_master;
    localparam int LEN_W = 2;

    typedef struct packed {
        logic         req;
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wd;
        logic [15:0]  ws;
        logic         rv;
        logic         last;
        logic         err;
        logic [127:0] rd;
        logic         busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // expectations keyed by cycle number
    exp_t exp_q [int];
    int   last_exp = 0;

    // reference line contents (what reads must return) and the memory device contents
    logic [127:0] ref_mem [logic [27:0]];
    logic [127:0] dev_mem [logic [27:0]];

    // memory behaviour knobs
    logic mem_never = 1'b0;
    logic gnt_force = 1'b0;

    // records kept by the compare process
    logic [31:0]  q_addr [$];
    int           q_rsp_cyc [$];
    logic [127:0] q_rsp_dat [$];
    logic         q_last [$];
    logic         q_err [$];
    int           req_cnt = 0;

    mem_line_master_if #(.MAX_BEATS(4)) m ();

    mem_line_master #(.MAX_BEATS(4), .LEN_W(LEN_W), .TIMEOUT_CYC(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (m.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pat(input logic [27:0] ln);
        return {ln, 4'h1, ln, 4'h2, ln, 4'h3, ln, 4'h4};
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] wd,
                                           input logic [15:0] ws);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic exp_t get_exp(input int t);
        if (exp_q.exists(t)) return exp_q[t];
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Line memory: grant is registered (follows req by one cycle), access happens on req&&gnt,
    // read data returns the cycle after the access.
    logic         gnt_int = 1'b0;
    logic         mx_gnt, mx_rv;
    logic [127:0] mx_rd;
    logic [27:0]  mx_ln;
    initial begin
        m.gnt = 1'b0; m.rvalid = 1'b0; m.rdata = '0;
        forever begin
            @(negedge clk);
            mx_gnt = m.req && !mem_never;
            mx_rv  = 1'b0;
            mx_rd  = '0;
            if (m.req && gnt_int && !rst_ni) begin
                mx_ln = m.addr[31:4];
                if (m.we) begin
                    dev_mem[mx_ln] = merge(dev_mem.exists(mx_ln) ? dev_mem[mx_ln] : pat(mx_ln),
                                           m.wdata, m.wstrb);
                end else begin
                    mx_rv = 1'b1;
                    mx_rd = dev_mem.exists(mx_ln) ? dev_mem[mx_ln] : pat(mx_ln);
                end
            end
            @(posedge clk); #1;
            gnt_int  = mx_gnt;
            m.gnt    = mx_gnt | gnt_force;
            m.rvalid = mx_rv;
            m.rdata  = mx_rd;
        end
    end

    // Compare process: every cycle against the expected timeline.
    exp_t ce;
    logic prev_req = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            ce = get_exp(cyc);
            chk("req", m.req, ce.req);
            chk("cmd_ready", m.cmd_ready, !rst_ni && !ce.busy);
            chk("rsp_valid", m.rsp_valid, ce.rv);
            if (ce.req) begin
                chk("addr", m.addr, ce.addr);
                chk("we", m.we, ce.we);
                if (ce.we) begin
                    chk("wdata", m.wdata, ce.wd);
                    chk("wstrb", m.wstrb, ce.ws);
                end
            end
            if (ce.rv) begin
                chk("rsp_last", m.rsp_last, ce.last);
                chk("rsp_err", m.rsp_err, ce.err);
                chk("rsp_rdata", m.rsp_rdata, ce.rd);
            end
            if (m.req) req_cnt++;
            if (m.req && !prev_req) q_addr.push_back(m.addr);
            prev_req = m.req;
            if (m.rsp_valid) begin
                q_rsp_cyc.push_back(cyc);
                q_rsp_dat.push_back(m.rsp_rdata);
                q_last.push_back(m.rsp_last);
                q_err.push_back(m.rsp_err);
            end
        end
    end

    task automatic set_exp(input int t, input exp_t e);
        exp_q[t] = e;
        if (t > last_exp) last_exp = t;
    endtask

    // Issue one command and lay out the timeline it must produce:
    // req two cycles per memory access, write rsp 3 cycles after accept, read beat k
    // rsp 4+3k cycles after accept, timeout rsp 17 cycles after accept.
    task automatic issue(input logic we, input logic [31:0] a, input int len,
                         input logic [127:0] wd, input logic [15:0] ws, input bit tmo,
                         output int t0);
        int   n;
        exp_t e;
        logic [27:0] ln;
        @(posedge clk); #1;
        m.cmd_valid = 1'b1; m.cmd_we = we; m.cmd_addr = a; m.cmd_len = LEN_W'(len);
        m.cmd_wdata = wd; m.cmd_wstrb = ws;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m.cmd_ready && n < 100);
        t0 = cyc;
        if (!m.cmd_ready) begin
            checks++; failures++;
            $display("FAIL accept: cmd_ready never rose, got 0 expected 1");
        end else begin
            ln = a[31:4];
            if (tmo) begin
                for (int k = 1; k <= 17; k++) begin
                    e = get_exp(t0 + k);
                    e.busy = 1'b1;
                    if (k <= 16) begin e.req = 1'b1; e.addr = {ln, 4'h0}; e.we = we; e.wd = wd; e.ws = ws; end
                    else begin e.rv = 1'b1; e.last = 1'b1; e.err = 1'b1; e.rd = '0; end
                    set_exp(t0 + k, e);
                end
            end else if (we) begin
                for (int k = 1; k <= 3; k++) begin
                    e = get_exp(t0 + k);
                    e.busy = 1'b1;
                    if (k <= 2) begin e.req = 1'b1; e.addr = {ln, 4'h0}; e.we = 1'b1; e.wd = wd; e.ws = ws; end
                    else begin e.rv = 1'b1; e.last = 1'b1; e.err = 1'b0; e.rd = '0; end
                    set_exp(t0 + k, e);
                end
                ref_mem[ln] = merge(ref_mem.exists(ln) ? ref_mem[ln] : pat(ln), wd, ws);
            end else begin
                for (int k = 0; k <= len; k++) begin
                    logic [27:0] lk;
                    lk = ln + 28'(k);
                    for (int j = 1; j <= 3; j++) begin
                        e = get_exp(t0 + 3*k + j);
                        e.busy = 1'b1;
                        if (j <= 2) begin e.req = 1'b1; e.addr = {lk, 4'h0}; e.we = 1'b0; end
                        set_exp(t0 + 3*k + j, e);
                    end
                    e = get_exp(t0 + 3*k + 4);
                    e.rv = 1'b1; e.last = (k == len); e.err = 1'b0;
                    e.rd = ref_mem.exists(lk) ? ref_mem[lk] : pat(lk);
                    set_exp(t0 + 3*k + 4, e);
                end
            end
        end
        @(posedge clk); #1;
        m.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc <= last_exp || !m.cmd_ready) && n < 300);
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic clear_rec();
        q_addr.delete(); q_rsp_cyc.delete(); q_rsp_dat.delete(); q_last.delete(); q_err.delete();
        req_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    int t0, t1;
    initial begin
        m.cmd_valid = 1'b0; m.cmd_we = 1'b0; m.cmd_addr = '0; m.cmd_len = '0;
        m.cmd_wdata = '0; m.cmd_wstrb = '0;
        #1 rst_ni = 1'b1;
        #1;
        chk("rst_req", m.req, 1'b0);
        chk("rst_we", m.we, 1'b0);
        chk("rst_addr", m.addr, 32'h0);
        chk("rst_wdata", m.wdata, 128'h0);
        chk("rst_wstrb", m.wstrb, 16'h0);
        chk("rst_rsp", {m.rsp_valid, m.rsp_last, m.rsp_err}, 3'b000);
        chk("rst_rdata", m.rsp_rdata, 128'h0);
        chk("rst_ready", m.cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_ni = 1'b0;

        // 1: write then readback
        clear_rec();
        issue(1'b1, 32'h100, 0, 128'hCAFEF00D_12345678_9ABCDEF0_DEADBEEF, 16'h000F, 1'b0, t0);
        wait_idle();
        chk("t1_wr_req_cycles", req_cnt, 2);
        chk("t1_wr_rsp_cnt", q_rsp_cyc.size(), 1);
        if (q_rsp_cyc.size() == 1) chk("t1_wr_rsp_lat", q_rsp_cyc[0] - t0, 3);
        if (q_addr.size() == 1) chk("t1_wr_addr", q_addr[0], 32'h100);
        clear_rec();
        issue(1'b0, 32'h100, 0, '0, '0, 1'b0, t0);
        wait_idle();
        chk("t1_rd_cnt", q_rsp_dat.size(), 1);
        if (q_rsp_dat.size() == 1)
            chk("t1_rd_data", q_rsp_dat[0], 128'h00000101_00000102_00000103_DEADBEEF);

        // 2: 4-beat burst from unaligned address
        clear_rec();
        issue(1'b0, 32'h208, 3, '0, '0, 1'b0, t0);
        wait_idle();
        chk("t2_addr_cnt", q_addr.size(), 4);
        chk("t2_rsp_cnt", q_rsp_cyc.size(), 4);
        if (q_addr.size() == 4) begin
            chk("t2_addr0", q_addr[0], 32'h200);
            chk("t2_addr1", q_addr[1], 32'h210);
            chk("t2_addr2", q_addr[2], 32'h220);
            chk("t2_addr3", q_addr[3], 32'h230);
        end
        if (q_rsp_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("t2_rsp_spacing", q_rsp_cyc[i] - q_rsp_cyc[i-1], 3);
            for (int i = 0; i < 4; i++) chk("t2_last", q_last[i], (i == 3));
            chk("t2_data3", q_rsp_dat[3], 128'h00000231_00000232_00000233_00000234);
        end

        // 3: back-to-back write/read with gnt stuck high (stale grant)
        gnt_force = 1'b1;
        clear_rec();
        issue(1'b1, 32'h140, 0, 128'h11112222_33334444_55556666_77778888, 16'hFFFF, 1'b0, t0);
        issue(1'b0, 32'h140, 0, '0, '0, 1'b0, t1);
        wait_idle();
        gnt_force = 1'b0;
        chk("t3_cmd_to_cmd", t1 - t0, 4);
        chk("t3_req_cycles", req_cnt, 4);
        chk("t3_rsp_cnt", q_rsp_dat.size(), 2);
        if (q_rsp_dat.size() == 2)
            chk("t3_rd_data", q_rsp_dat[1], 128'h11112222_33334444_55556666_77778888);

        // 4: memory never grants
        mem_never = 1'b1;
        clear_rec();
        issue(1'b0, 32'h300, 1, '0, '0, 1'b1, t0);
        wait_idle();
        mem_never = 1'b0;
        chk("t4_req_cycles", req_cnt, 16);
        chk("t4_rsp_cnt", q_rsp_cyc.size(), 1);
        if (q_rsp_cyc.size() == 1) begin
            chk("t4_rsp_lat", q_rsp_cyc[0] - t0, 17);
            chk("t4_err_last", {q_err[0], q_last[0]}, 2'b11);
        end

        // 5: address wrap
        clear_rec();
        issue(1'b0, 32'hFFFFFFF0, 1, '0, '0, 1'b0, t0);
        wait_idle();
        chk("t5_addr_cnt", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            chk("t5_addr0", q_addr[0], 32'hFFFFFFF0);
            chk("t5_addr1", q_addr[1], 32'h00000000);
        end
        if (q_rsp_dat.size() == 2) begin
            chk("t5_data0", q_rsp_dat[0], 128'hFFFFFFF1_FFFFFFF2_FFFFFFF3_FFFFFFF4);
            chk("t5_data1", q_rsp_dat[1], 128'h00000001_00000002_00000003_00000004);
        end

        // 7: wstrb=0 write still acknowledged, line unchanged
        clear_rec();
        issue(1'b1, 32'h600, 0, {4{32'hBADBAD00}}, 16'h0000, 1'b0, t0);
        issue(1'b0, 32'h600, 0, '0, '0, 1'b0, t1);
        wait_idle();
        chk("t7_rsp_cnt", q_rsp_dat.size(), 2);
        if (q_rsp_dat.size() == 2)
            chk("t7_data", q_rsp_dat[1], 128'h00000601_00000602_00000603_00000604);

        // 6: reset during RDATA of beat 2, then a fresh read
        clear_rec();
        issue(1'b0, 32'h400, 2, '0, '0, 1'b0, t0);
        while (cyc < t0 + 6) @(negedge clk);
        #2 rst_ni = 1'b1;
        for (int k = t0 + 7; k <= t0 + 20; k++) if (exp_q.exists(k)) exp_q.delete(k);
        last_exp = cyc;
        #1;
        chk("t6_req_in_rst", m.req, 1'b0);
        chk("t6_rsp_in_rst", m.rsp_valid, 1'b0);
        chk("t6_ready_in_rst", m.cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_ready_after", m.cmd_ready, 1'b1);
        chk("t6_rsp_cnt_aborted", q_rsp_cyc.size(), 1);
        clear_rec();
        issue(1'b0, 32'h500, 0, '0, '0, 1'b0, t0);
        wait_idle();
        chk("t6_fresh_cnt", q_rsp_dat.size(), 1);
        if (q_rsp_dat.size() == 1)
            chk("t6_fresh_data", q_rsp_dat[0], 128'h00000501_00000502_00000503_00000504);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
